svm_stage_sequencer: RTL and testbench



---
 rtl/svm_pkg.sv | 23 ++
 rtl/svm_stage_sequencer_if.sv | 49 ++++
 rtl/svm_seq_counter.sv | 23 ++
 rtl/svm_stage_sequencer.sv | 153 +++++++++++++++
 tb/tb_svm_stage_sequencer.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/svm_pkg.sv
// rtl/svm_pkg.sv - shared types and constants for the SVM stage sequencer
package svm_pkg;

  typedef enum logic [2:0] {
    IDLE, CLEAR, ACCUM, FLUSH, LOAD, DRAIN, WAIT_K, DONE
  } seqState_t;

  // Ceiling log2, never below 1 so every derived width is legal.
  function automatic int log2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Cycles spent from CLEAR through DONE for a window with no stalls.
  function automatic int windowCycles(input int dim, input int maxColumn, input int kernelLat);
    return 1 + dim + maxColumn + 1 + maxColumn + kernelLat + 1;
  endfunction

endpackage

// File: rtl/svm_stage_sequencer_if.sv
// rtl/svm_stage_sequencer_if.sv - sequencer-to-stage signal bundle
// cycle_count is present only when SVM_SEQ_PERF_EN is defined.
interface svm_stage_sequencer_if #(
  parameter int MAX_COLUMN = 10,
  parameter int DIM        = 1024
);
  import svm_pkg::*;

  localparam int IDX_W  = log2(MAX_COLUMN);
  localparam int ADDR_W = log2(DIM);

  logic              start;
  logic              busy;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [ADDR_W-1:0] sv_addr;
  logic              resetVU;
  logic              enableVU;
  logic              mu;
  logic              lastData;
  logic              resetSU;
  logic              enableSU;
  logic [IDX_W-1:0]  alpha_index;
  logic              class_in;
  logic              result_valid;
  logic              result_class;
`ifdef SVM_SEQ_PERF_EN
  logic [31:0]       cycle_count;
`endif

  modport master (
    input  start, pixel_valid, class_in,
`ifdef SVM_SEQ_PERF_EN
    output cycle_count,
`endif
    output busy, pixel_ready, sv_addr, resetVU, enableVU, mu, lastData,
           resetSU, enableSU, alpha_index, result_valid, result_class
  );

  modport slave (
    output start, pixel_valid, class_in,
`ifdef SVM_SEQ_PERF_EN
    input  cycle_count,
`endif
    input  busy, pixel_ready, sv_addr, resetVU, enableVU, mu, lastData,
           resetSU, enableSU, alpha_index, result_valid, result_class
  );

endinterface

// File: rtl/svm_seq_counter.sv
// rtl/svm_seq_counter.sv - loadable up-counter with terminal-count flag
module svm_seq_counter #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  input  logic         inc,
  input  logic [W-1:0] tcVal,
  output logic [W-1:0] count,
  output logic         tc
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)    count <= '0;
    else if (load) count <= loadVal;
    else if (inc)  count <= count + 1'b1;
  end

  assign tc = (count == tcVal);

endmodule

// File: rtl/svm_stage_sequencer.sv
// rtl/svm_stage_sequencer.sv - window sequencer for the VU chain and kernel unit
// Optional SVM_SEQ_PERF_EN adds a saturating per-window cycle counter on cycle_count.
module svm_stage_sequencer
  import svm_pkg::*;
#(
  parameter int MAX_COLUMN = 10,
  parameter int DIM        = 1024,
  parameter int KERNEL_LAT = 2
) (
  input logic                  clock,
  input logic                  reset,
  svm_stage_sequencer_if.master seq
);

  localparam int IDX_W  = log2(MAX_COLUMN);
  localparam int ADDR_W = log2(DIM);
  localparam int PIX_W  = log2(DIM + 1);
  localparam int PH_MAX = (MAX_COLUMN > KERNEL_LAT) ? MAX_COLUMN : KERNEL_LAT;
  localparam int PH_W   = log2(PH_MAX + 1);

  localparam logic [PIX_W-1:0] LAST_PIX  = PIX_W'(DIM - 1);
  localparam logic [PH_W-1:0]  COL_LAST  = PH_W'(MAX_COLUMN - 1);
  localparam logic [PH_W-1:0]  KLAT_LAST = PH_W'(KERNEL_LAT - 1);

  seqState_t         state, nextState;
  logic [PIX_W-1:0]  pixCnt;
  logic              pixLast;
  logic [PH_W-1:0]   phaseCnt, phaseLastVal;
  logic              phaseDone, phaseLoad, phaseInc;
  logic              accept;

  logic              busyD, clearD, enVuD, lastD, muD, enSuD, rvD, classD;
  logic [ADDR_W-1:0] svAddrD;
  logic [IDX_W-1:0]  alphaD;
  logic              busyQ, clearQ, enVuQ, lastQ, muQ, enSuQ, rvQ, classQ;
  logic [ADDR_W-1:0] svAddrQ;
  logic [IDX_W-1:0]  alphaQ;

  assign accept       = (state == ACCUM) && seq.pixel_valid;
  assign phaseLastVal = (state == WAIT_K) ? KLAT_LAST : COL_LAST;
  assign phaseLoad    = (state != nextState);
  assign phaseInc     = state inside {FLUSH, DRAIN, WAIT_K};

  svm_seq_counter #(.W(PIX_W)) u_pixCnt (
    .clock(clock), .reset(reset),
    .load(state == CLEAR), .loadVal('0), .inc(accept),
    .tcVal(LAST_PIX), .count(pixCnt), .tc(pixLast)
  );

  // Restarted on every state change, so each timed phase counts from zero.
  svm_seq_counter #(.W(PH_W)) u_phaseCnt (
    .clock(clock), .reset(reset),
    .load(phaseLoad), .loadVal('0), .inc(phaseInc),
    .tcVal(phaseLastVal), .count(phaseCnt), .tc(phaseDone)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (seq.start) nextState = CLEAR;
      CLEAR:   nextState = ACCUM;
      ACCUM:   if (accept && pixLast) nextState = FLUSH;
      FLUSH:   if (phaseDone) nextState = LOAD;
      LOAD:    nextState = DRAIN;
      DRAIN:   if (phaseDone) nextState = WAIT_K;
      WAIT_K:  if (phaseDone) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state and registered, so they line up with it.
  always_comb begin
    busyD   = (nextState != IDLE);
    clearD  = (nextState == CLEAR);
    enVuD   = accept;
    lastD   = accept && pixLast;
    svAddrD = accept ? ADDR_W'(pixCnt) : svAddrQ;
    muD     = (nextState == LOAD);
    enSuD   = (nextState == DRAIN);
    alphaD  = '0;
    if (nextState == DRAIN) begin
      alphaD = (state == DRAIN) ? IDX_W'(MAX_COLUMN - 2) - IDX_W'(phaseCnt)
                                : IDX_W'(MAX_COLUMN - 1);
    end
    rvD     = (state == DONE);
    classD  = (state == DONE) ? seq.class_in : classQ;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busyQ   <= 1'b0;
      clearQ  <= 1'b0;
      enVuQ   <= 1'b0;
      lastQ   <= 1'b0;
      svAddrQ <= '0;
      muQ     <= 1'b0;
      enSuQ   <= 1'b0;
      alphaQ  <= '0;
      rvQ     <= 1'b0;
      classQ  <= 1'b0;
    end else begin
      busyQ   <= busyD;
      clearQ  <= clearD;
      enVuQ   <= enVuD;
      lastQ   <= lastD;
      svAddrQ <= svAddrD;
      muQ     <= muD;
      enSuQ   <= enSuD;
      alphaQ  <= alphaD;
      rvQ     <= rvD;
      classQ  <= classD;
    end
  end

  assign seq.busy         = busyQ;
  assign seq.pixel_ready  = (state == ACCUM);
  assign seq.sv_addr      = svAddrQ;
  assign seq.resetVU      = clearQ;
  assign seq.resetSU      = clearQ;
  assign seq.enableVU     = enVuQ;
  assign seq.lastData     = lastQ;
  assign seq.mu           = muQ;
  assign seq.enableSU     = enSuQ;
  assign seq.alpha_index  = alphaQ;
  assign seq.result_valid = rvQ;
  assign seq.result_class = classQ;

`ifdef SVM_SEQ_PERF_EN
  logic [31:0] runCnt, runInc, cycleCountQ;

  assign runInc = (&runCnt) ? runCnt : runCnt + 32'd1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      runCnt      <= '0;
      cycleCountQ <= '0;
    end else begin
      if (state == CLEAR)     runCnt <= 32'd1;
      else if (state != IDLE) runCnt <= runInc;
      if (state == DONE)      cycleCountQ <= runInc;
    end
  end

  assign seq.cycle_count = cycleCountQ;
`endif

endmodule

// File: tb/tb_svm_stage_sequencer.sv
// tb/tb_svm_stage_sequencer.sv - self-checking bench for svm_stage_sequencer
module tb_svm_stage_sequencer;

  localparam int MC   = 4;
  localparam int DIMP = 8;
  localparam int KL   = 2;
  localparam int AW   = svm_pkg::log2(DIMP);
  localparam int IW   = svm_pkg::log2(MC);

  typedef struct {
    string        tag;
    logic [127:0] pv;
    logic         cls;
    int           extraStart;
    int           expRes;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   nRun  = 0;
  int   nFail = 0;
  logic lastCls = 1'b0;
  vec_t tbl[5];

  always #5 clock = ~clock;

  svm_stage_sequencer_if #(.MAX_COLUMN(MC), .DIM(DIMP)) sif ();

  svm_stage_sequencer #(.MAX_COLUMN(MC), .DIM(DIMP), .KERNEL_LAT(KL)) dut (
    .clock(clock),
    .reset(reset),
    .seq  (sif)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nRun++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] allOutputs();
    return 64'({sif.busy, sif.pixel_ready, sif.resetVU, sif.resetSU, sif.enableVU,
                sif.lastData, sif.mu, sif.enableSU, sif.result_valid, sif.result_class,
                sif.sv_addr, sif.alpha_index});
  endfunction

  // Expected timeline derived from the accept cycles: each phase follows the last accept.
  task automatic runWindow(input string tag, input logic [127:0] pv, input logic cls,
                           input int extraStart, output int resSeen, output int nEn,
                           output int nRv);
    int accCyc[DIMP];
    int nAcc, la, loadC, drainS, doneC, resC, pIdx;
    logic eBusy, eRdy, eRst, eEn, eLast, eMu, eSu, eRv, eCls;
    logic [AW-1:0] eAddr, aAddr;
    logic [IW-1:0] eAlpha, aAlpha;
    logic [63:0] expV, actV;
    nAcc = 0;
    for (int c = 2; nAcc < DIMP && c < 128; c++) begin
      if (pv[c]) begin
        accCyc[nAcc] = c;
        nAcc++;
      end
    end
    la     = accCyc[DIMP-1];
    doneC  = svm_pkg::windowCycles(DIMP, MC, KL) + (la - (DIMP + 1));
    loadC  = la + MC + 1;
    drainS = loadC + 1;
    resC   = doneC + 1;
    resSeen = -1;
    nEn = 0;
    nRv = 0;
    for (int t = 0; t <= resC + 2; t++) begin
      @(negedge clock);
      pIdx = -1;
      for (int i = 0; i < DIMP; i++) if (accCyc[i] == t - 1) pIdx = i;
      eBusy  = (t >= 1) && (t <= doneC);
      eRdy   = (t >= 2) && (t <= la);
      eRst   = (t == 1);
      eEn    = (pIdx >= 0);
      eAddr  = eEn ? AW'(pIdx) : '0;
      eLast  = (t == la + 1);
      eMu    = (t == loadC);
      eSu    = (t >= drainS) && (t < drainS + MC);
      eAlpha = eSu ? IW'(MC - 1 - (t - drainS)) : '0;
      eRv    = (t == resC);
      eCls   = (t >= resC) ? cls : lastCls;
      aAddr  = eEn ? sif.sv_addr : '0;
      aAlpha = eSu ? sif.alpha_index : '0;
      expV = 64'({eBusy, eRdy, eRst, eRst, eEn, eLast, eMu, eSu, eRv, eCls, eAddr, eAlpha});
      actV = 64'({sif.busy, sif.pixel_ready, sif.resetVU, sif.resetSU, sif.enableVU,
                  sif.lastData, sif.mu, sif.enableSU, sif.result_valid, sif.result_class,
                  aAddr, aAlpha});
      check($sformatf("%s cycle %0d outputs", tag, t), actV, expV);
      if (sif.enableVU) nEn++;
      if (sif.result_valid) begin
        nRv++;
        if (resSeen < 0) resSeen = t;
      end
      sif.start       = (t == 0) || (t == extraStart);
      sif.pixel_valid = pv[t];
      sif.class_in    = (t == doneC) ? cls : ~cls;
    end
    sif.start       = 1'b0;
    sif.pixel_valid = 1'b0;
`ifdef SVM_SEQ_PERF_EN
    check($sformatf("%s cycle_count", tag), 64'(sif.cycle_count), 64'(doneC));
`endif
    lastCls = cls;
  endtask

  task automatic resetMidDrain();
    int nRv;
    for (int t = 0; t <= 16; t++) begin
      @(negedge clock);
      sif.start       = (t == 0);
      sif.pixel_valid = 1'b1;
    end
    check("in DRAIN before reset", 64'(sif.enableSU), 64'd1);
    #2 reset = 1'b0;
    #1 check("async reset clears outputs", allOutputs(), 64'd0);
`ifdef SVM_SEQ_PERF_EN
    check("async reset clears cycle_count", 64'(sif.cycle_count), 64'd0);
`endif
    sif.start       = 1'b0;
    sif.pixel_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    nRv = 0;
    repeat (30) begin
      @(negedge clock);
      if (sif.result_valid) nRv++;
    end
    check("no result after aborted window", 64'(nRv), 64'd0);
    lastCls = 1'b0;
  endtask

  initial begin
    logic [127:0] nom, pv;
    int resSeen, nEn, nRv, extra;
    logic cls;

    nom = '1;
    tbl[0] = '{"nominal",        nom, 1'b1, -1, 22};
    pv = nom; pv[5] = 1'b0; pv[6] = 1'b0; pv[10] = 1'b0; pv[11] = 1'b0;
    tbl[1] = '{"stalls",         pv,  1'b0, -1, 26};
    tbl[2] = '{"start_busy",     nom, 1'b0,  5, 22};
    pv = nom; pv[2] = 1'b0; pv[3] = 1'b0;
    tbl[3] = '{"first_stall",    pv,  1'b1, -1, 24};
    pv = nom; pv[9] = 1'b0;
    tbl[4] = '{"last_stall",     pv,  1'b0, -1, 23};

    sif.start       = 1'b0;
    sif.pixel_valid = 1'b0;
    sif.class_in    = 1'b0;
    repeat (3) @(negedge clock);
    check("reset state", allOutputs(), 64'd0);
`ifdef SVM_SEQ_PERF_EN
    check("reset cycle_count", 64'(sif.cycle_count), 64'd0);
`endif
    reset = 1'b1;
    repeat (2) @(negedge clock);

    for (int i = 0; i < 5; i++) begin
      runWindow(tbl[i].tag, tbl[i].pv, tbl[i].cls, tbl[i].extraStart, resSeen, nEn, nRv);
      check($sformatf("%s result cycle", tbl[i].tag), 64'(resSeen), 64'(tbl[i].expRes));
      check($sformatf("%s enableVU count", tbl[i].tag), 64'(nEn), 64'(DIMP));
      check($sformatf("%s result pulses", tbl[i].tag), 64'(nRv), 64'd1);
    end

    resetMidDrain();
    runWindow("after_reset", nom, 1'b1, -1, resSeen, nEn, nRv);
    check("after_reset result cycle", 64'(resSeen), 64'd22);
    check("after_reset result pulses", 64'(nRv), 64'd1);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 128; i++) pv[i] = (i >= 40) ? 1'b1 : ($urandom_range(0, 9) < 7);
      cls   = 1'($urandom_range(0, 1));
      extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 20)) : -1;
      runWindow($sformatf("random%0d", r), pv, cls, extra, resSeen, nEn, nRv);
      check($sformatf("random%0d enableVU count", r), 64'(nEn), 64'(DIMP));
      check($sformatf("random%0d result pulses", r), 64'(nRv), 64'd1);
    end

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
